// File: rtl/spdif_pkg.sv
// Shared constants for the S/PDIF biphase-mark line stage: preamble codes, patterns, FSM encoding.
// Optional build macro used by the top: SPDIF_PARITY_GEN_EN.
package spdif_pkg;

    localparam logic [3:0] PRE_B = 4'd1;
    localparam logic [3:0] PRE_M = 4'd2;
    localparam logic [3:0] PRE_W = 4'd3;

    // Patterns are for a line sitting at 0 before the preamble; MSB goes out first.
    localparam logic [7:0] PAT_B = 8'b1110_1000;
    localparam logic [7:0] PAT_M = 8'b1110_0010;
    localparam logic [7:0] PAT_W = 8'b1110_0100;

    localparam int UI_PER_SUBFRAME = 64;
    localparam int PREAMBLE_UI     = 8;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PREAMBLE = 2'd1;
    localparam logic [1:0] ST_DATA     = 2'd2;

    // Unknown codes (including 0) fall back to M.
    function automatic logic [7:0] preamble_pattern(input logic [3:0] code, input logic level);
        logic [7:0] pat;
        case (code)
            PRE_B:   pat = PAT_B;
            PRE_W:   pat = PAT_W;
            default: pat = PAT_M;
        endcase
        return pat ^ {8{level}};
    endfunction

endpackage

// File: rtl/spdif_ui_tick.sv
// Free-running unit-interval divider: one-cycle tick every UI_DIV clocks, never re-phased.
module spdif_ui_tick #(
    parameter int UI_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick_o
);

    localparam int DIV_W = $clog2(UI_DIV);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    assign tick_o = (div_q == DIV_W'(UI_DIV - 1));

    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (tick_o) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/spdif_bmc_tx.sv
// S/PDIF subframe serialiser: holding + shift register, preamble insertion and biphase-mark coding.
// Build macro SPDIF_PARITY_GEN_EN: regenerate slot 31 as even parity instead of sending data_rx[31].
module spdif_bmc_tx
    import spdif_pkg::*;
#(
    parameter int UI_DIV = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] data_rx,
    input  logic        valid_rx,
    output logic        ready_rx,
    output logic        spdif_out,
    output logic        underrun
);

    logic        tick;
    logic        load;
    logic        start_frame;
    logic [31:0] load_word;
    logic [5:0]  ui_next;

    logic [31:0] hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic [31:0] shift_q, shift_d;
    logic [7:0]  pre_q, pre_d;
    logic [1:0]  state_q, state_d;
    logic [5:0]  ui_q, ui_d;
    logic        line_q, line_d;
    logic        underrun_q, underrun_d;

    spdif_ui_tick #(
        .UI_DIV (UI_DIV)
    ) u_ui_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick_o  (tick)
    );

    assign ready_rx  = ~hold_full_q;
    assign spdif_out = line_q;
    assign underrun  = underrun_q;
    assign load      = valid_rx & ready_rx;
    assign ui_next   = ui_q + 6'd1;

`ifdef SPDIF_PARITY_GEN_EN
    assign load_word = {^data_rx[30:4], data_rx[30:0]};
`else
    assign load_word = data_rx;
`endif

    // A new subframe starts on a tick from IDLE or at the last UI, but only with a word waiting.
    assign start_frame = tick & hold_full_q &
                         ((state_q == ST_IDLE) || (ui_q == 6'(UI_PER_SUBFRAME - 1)));

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        pre_d       = pre_q;
        state_d     = state_q;
        ui_d        = ui_q;
        line_d      = line_q;
        underrun_d  = 1'b0;

        if (start_frame) begin
            hold_full_d = 1'b0;
        end
        if (load) begin
            hold_d      = load_word;
            hold_full_d = 1'b1;
        end

        if (start_frame) begin
            shift_d = hold_q;
            pre_d   = preamble_pattern(hold_q[3:0], line_q);
            state_d = ST_PREAMBLE;
            ui_d    = 6'd0;
            line_d  = pre_d[7];
        end else if (tick && (state_q != ST_IDLE)) begin
            if (ui_q == 6'(UI_PER_SUBFRAME - 1)) begin
                state_d    = ST_IDLE;
                ui_d       = 6'd0;
                underrun_d = 1'b1;
            end else if (ui_next < 6'(PREAMBLE_UI)) begin
                ui_d   = ui_next;
                line_d = pre_q[3'd7 - ui_next[2:0]];
            end else begin
                // Even UI opens a slot (always toggle); odd UI is mid-slot (toggle on a 1).
                ui_d    = ui_next;
                state_d = ST_DATA;
                if (!ui_next[0] || shift_q[ui_next[5:1]]) begin
                    line_d = ~line_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            pre_q       <= '0;
            state_q     <= ST_IDLE;
            ui_q        <= '0;
            line_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            pre_q       <= pre_d;
            state_q     <= state_d;
            ui_q        <= ui_d;
            line_q      <= line_d;
            underrun_q  <= underrun_d;
        end
    end

endmodule

// File: tb/tb_spdif_bmc_tx.sv
// Scoreboard bench for spdif_bmc_tx: expected 64-UI line images queued on accept, compared per subframe.
module tb_spdif_bmc_tx;

    localparam int UI_DIV = 4;

    logic        clk;
    logic        resetN;
    logic [31:0] dataRx;
    logic        validRx;
    logic        readyRx;
    logic        spdifOut;
    logic        underrun;

    int          checks;
    int          failures;
    int          cycleCnt;
    int          lastAccept;
    logic        modelLevel;
    logic [63:0] expQ[$];

    spdif_bmc_tx #(
        .UI_DIV (UI_DIV)
    ) dut (
        .clk       (clk),
        .reset_n   (resetN),
        .data_rx   (dataRx),
        .valid_rx  (validRx),
        .ready_rx  (readyRx),
        .spdif_out (spdifOut),
        .underrun  (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference line image: bit 63 is UI 0; preamble table taken straight from the line format.
    function automatic logic [63:0] expectUi(input logic [31:0] w, input logic prior);
        logic [7:0]  pat;
        logic [63:0] u;
        logic        lvl;
        logic        b;
        case (w[3:0])
            4'd1:    pat = 8'b11101000;
            4'd3:    pat = 8'b11100100;
            default: pat = 8'b11100010;
        endcase
        if (prior) pat = ~pat;
        u = '0;
        u[63:56] = pat;
        lvl = pat[0];
        for (int s = 4; s < 32; s++) begin
            b = w[s];
`ifdef SPDIF_PARITY_GEN_EN
            if (s == 31) b = ^w[30:4];
`endif
            lvl = ~lvl;
            u[63 - 2*s] = lvl;
            if (b) lvl = ~lvl;
            u[62 - 2*s] = lvl;
        end
        return u;
    endfunction

    task automatic applyStimulus(input logic [31:0] w, input bit markLatency);
        int n;
        logic [63:0] img;
        n = 0;
        @(negedge clk);
        dataRx  = w;
        validRx = 1'b1;
        while (!readyRx && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checkOutput("acceptTimeout", 64'd0, 64'd1);
            validRx = 1'b0;
            return;
        end
        if (markLatency) lastAccept = cycleCnt + 1;
        img = expectUi(w, modelLevel);
        expQ.push_back(img);
        modelLevel = img[0];
        @(negedge clk);
        validRx = 1'b0;
    endtask

    // Waits for the preamble edge, then samples n back-to-back subframes mid-UI.
    task automatic watchSubframes(input int n);
        logic        prevLevel;
        logic [63:0] got;
        logic [63:0] exp;
        int          waitCnt;
        int          lat;
        prevLevel = spdifOut;
        waitCnt = 0;
        got = '0;
        @(negedge clk);
        while (spdifOut == prevLevel && waitCnt < 3000) begin
            @(negedge clk);
            waitCnt++;
        end
        if (waitCnt >= 3000) begin
            checkOutput("startTimeout", 64'd0, 64'd1);
            return;
        end
        lat = cycleCnt - lastAccept;
        checkOutput("startLatency", 64'((lat >= 1) && (lat <= UI_DIV + 1)), 64'd1);
        for (int s = 0; s < n; s++) begin
            for (int i = 0; i < 64; i++) begin
                @(negedge clk);
                got[63 - i] = spdifOut;
                repeat (UI_DIV - 1) @(negedge clk);
            end
            if (expQ.size() == 0) begin
                checkOutput("queueEmpty", 64'd0, 64'd1);
            end else begin
                exp = expQ.pop_front();
                checkOutput("subframe", got, exp);
            end
            checkOutput("underrunBoundary", 64'(underrun), 64'(s == n - 1));
        end
        checkOutput("lineHeld", 64'(spdifOut), 64'(got[0]));
        @(negedge clk);
        checkOutput("underrunPulse", 64'(underrun), 64'd0);
    endtask

    task automatic checkQuiet(input string tag, input int cycles);
        logic startLevel;
        int   toggles;
        startLevel = spdifOut;
        toggles = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (spdifOut !== startLevel) toggles++;
        end
        checkOutput(tag, 64'(toggles), 64'd0);
    endtask

    initial begin
        logic [31:0] w;
        logic [3:0]  codes [4];
        checks     = 0;
        failures   = 0;
        cycleCnt   = 0;
        lastAccept = 0;
        modelLevel = 1'b0;
        codes[0] = 4'd1; codes[1] = 4'd3; codes[2] = 4'd2; codes[3] = 4'd3;
        dataRx  = '0;
        validRx = 1'b0;
        resetN  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstSpdif", 64'(spdifOut), 64'd0);
        checkOutput("rstReady", 64'(readyRx), 64'd1);
        checkOutput("rstUnderrun", 64'(underrun), 64'd0);
        resetN = 1'b1;
        checkQuiet("rstNoToggle", 20);

        // Single all-zero B subframe, then underrun and a held line.
        fork
            applyStimulus(32'h0000_0001, 1'b1);
            watchSubframes(1);
        join
        checkQuiet("idleHeld", 30);
        checkOutput("readyIdle", 64'(readyRx), 64'd1);

        // Resume after a gap with slot 4 and P set.
        repeat (17) @(negedge clk);
        fork
            applyStimulus(32'h8000_0011, 1'b1);
            watchSubframes(1);
        join

        // Back-to-back B,W,M,W including odd-parity and wrong-P words, and code 0.
        fork
            begin
                applyStimulus(32'h0000_0011, 1'b1);
                applyStimulus(32'h1234_5673, 1'b0);
                applyStimulus(32'h8765_4322, 1'b0);
                applyStimulus(32'h4000_00F3, 1'b0);
                applyStimulus(32'h0000_0012, 1'b0);
                applyStimulus(32'h0000_0010, 1'b0);
            end
            watchSubframes(6);
        join

        // Random back-to-back traffic cycling B,W,M,W.
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    w = $urandom;
                    w[3:0] = codes[k % 4];
                    applyStimulus(w, (k == 0));
                end
            end
            watchSubframes(6);
        join

        // Reset with both registers occupied mid-subframe.
        applyStimulus(32'h0000_0F23, 1'b1);
        applyStimulus(32'h0000_0011, 1'b0);
        repeat (100) @(negedge clk);
        resetN = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midRstSpdif", 64'(spdifOut), 64'd0);
        checkOutput("midRstReady", 64'(readyRx), 64'd1);
        checkOutput("midRstUnderrun", 64'(underrun), 64'd0);
        expQ.delete();
        modelLevel = 1'b0;
        resetN = 1'b1;
        checkQuiet("midRstQuiet", 300);
        checkOutput("midRstReadyAfter", 64'(readyRx), 64'd1);
        checkOutput("midRstNoUnderrun", 64'(underrun), 64'd0);

        fork
            applyStimulus(32'h0000_0012, 1'b1);
            watchSubframes(1);
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
